// File: rtl/hex_tx_pkg.sv
// Shared types and ASCII constants for the hex result formatter.
package hex_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGIT,
        ST_ERR,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] CHR_MINUS = 8'h2D;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_E     = 8'h45;
    localparam logic [7:0] CHR_R     = 8'h52;

    // Number of leading zero nibbles in the low ndig nibbles of w (ndig <= 16).
    function automatic int unsigned lead_zero_nibs(input logic [63:0] w, input int unsigned ndig);
        int unsigned n;
        logic        done;
        n    = 0;
        done = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if ((unsigned'(i) < ndig) && !done) begin
                if (w[i*4 +: 4] == 4'h0) begin
                    n++;
                end else begin
                    done = 1'b1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/hex_nib_ascii.sv
// Nibble to uppercase ASCII hex digit; purely combinational.
module hex_nib_ascii (
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    always_comb begin
        if (nib < 4'd10) begin
            asc = 8'h30 + {4'h0, nib};
        end else begin
            asc = 8'h37 + {4'h0, nib};
        end
    end

endmodule

// File: rtl/hex_tx_fmt.sv
// Result word to ASCII hex byte stream ('-' / "ERR", digits, CR LF); HEX_LZS_EN skips leading zeros.
// Latency: first byte valid one cycle after capture, then one byte per accepted transfer.
// Backpressure: tx_data/tx_valid held until tx_ready; res_ready only while idle.
module hex_tx_fmt
    import hex_tx_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_neg,
    input  logic              res_err,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int NDIG  = DATA_W / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t            state;
    state_t            nxt_state;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  nxt_idx;
    logic [IDX_W-1:0]  start_idx;
    logic [1:0]        cnt_q;
    logic [1:0]        nxt_cnt;
    logic              capture;
    logic              advance;
    logic              load;
    logic [3:0]        nib;
    logic [7:0]        asc;
    logic [7:0]        nxt_byte;

    assign capture = res_valid & res_ready;
    assign advance = tx_valid & tx_ready;
    // Output register refills when empty or when its byte is taken this edge.
    assign load    = (state != ST_IDLE) & (~tx_valid | tx_ready);

`ifdef HEX_LZS_EN
    int unsigned lz;

    always_comb begin
        lz = lead_zero_nibs(64'(res_data), unsigned'(NDIG));
        if (lz > unsigned'(NDIG - 1)) begin
            lz = unsigned'(NDIG - 1);
        end
        start_idx = IDX_W'(unsigned'(NDIG - 1) - lz);
    end
`else
    assign start_idx = IDX_W'(NDIG - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx_q;
        nxt_cnt   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    nxt_idx = start_idx;
                    nxt_cnt = 2'd0;
                    if (res_err) begin
                        nxt_state = ST_ERR;
                    end else if (res_neg) begin
                        nxt_state = ST_SIGN;
                    end else begin
                        nxt_state = ST_DIGIT;
                    end
                end
            end
            ST_SIGN: begin
                if (advance) nxt_state = ST_DIGIT;
            end
            ST_DIGIT: begin
                if (advance) begin
                    if (idx_q == '0) begin
                        nxt_state = ST_CR;
                    end else begin
                        nxt_idx = idx_q - 1'b1;
                    end
                end
            end
            ST_ERR: begin
                if (advance) begin
                    if (cnt_q == 2'd2) begin
                        nxt_state = ST_CR;
                    end else begin
                        nxt_cnt = cnt_q + 2'd1;
                    end
                end
            end
            ST_CR: begin
                if (advance) nxt_state = ST_LF;
            end
            ST_LF: begin
                if (advance) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // The byte loaded is the one for the post-transition state, so it is
    // ready in the same edge that retires the previous byte.
    assign nib = data_q[{nxt_idx, 2'b00} +: 4];

    hex_nib_ascii u_nib_ascii (
        .nib (nib),
        .asc (asc)
    );

    always_comb begin
        res_ready = (state == ST_IDLE) & ~rst;
        busy      = (state != ST_IDLE);
        case (nxt_state)
            ST_SIGN:  nxt_byte = CHR_MINUS;
            ST_DIGIT: nxt_byte = asc;
            ST_ERR:   nxt_byte = (nxt_cnt == 2'd0) ? CHR_E : CHR_R;
            ST_CR:    nxt_byte = CHR_CR;
            ST_LF:    nxt_byte = CHR_LF;
            default:  nxt_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
            cnt_q  <= 2'd0;
        end else begin
            idx_q <= nxt_idx;
            cnt_q <= nxt_cnt;
            if (capture) begin
                data_q <= res_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (load) begin
            tx_valid <= (nxt_state != ST_IDLE);
            tx_data  <= nxt_byte;
        end
    end

endmodule

// File: tb/tb_hex_tx_fmt.sv
// Scoreboard bench for hex_tx_fmt: stimulus pushes expected frames, a negedge monitor pops and compares.
module tb_hex_tx_fmt;

    localparam int DATA_W = 32;
    localparam int NDIG   = DATA_W / 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              res_valid = 1'b0;
    logic              res_ready;
    logic [DATA_W-1:0] res_data = '0;
    logic              res_neg = 1'b0;
    logic              res_err = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              busy;

    int           n_checks = 0;
    int           n_fail   = 0;
    byte unsigned exp_q[$];
    int           pops     = 0;
    int           tx_mode  = 0;
    bit           hold_prev = 1'b0;
    logic [7:0]   prev_data = 8'h00;

    hex_tx_fmt #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_neg   (res_neg),
        .res_err   (res_err),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame built as a character string from the result value.
    function automatic int model_frame(input logic [DATA_W-1:0] d, input bit neg, input bit err);
        byte unsigned s[$];
        int           v;
        if (err) begin
            s = '{8'h45, 8'h52, 8'h52};
        end else begin
            for (int i = NDIG - 1; i >= 0; i--) begin
                v = int'((d >> (4 * i)) & 32'hF);
                s.push_back((v < 10) ? 8'(48 + v) : 8'(55 + v));
            end
`ifdef HEX_LZS_EN
            while (s.size() > 1 && s[0] == 8'h30) void'(s.pop_front());
`endif
            if (neg) s.push_front(8'h2D);
        end
        s.push_back(8'h0D);
        s.push_back(8'h0A);
        foreach (s[i]) exp_q.push_back(s[i]);
        return s.size();
    endfunction

    // Transmitter ready patterns: 0 always, 1 random, 2 one pulse per 434 cycles.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    tx_ready = (ph == 0);
                    ph = (ph + 1) % 434;
                end
            endcase
        end
    end

    initial begin
        byte unsigned e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                check("busy", busy, exp_q.size() != 0);
                check("res_ready", res_ready, exp_q.size() == 0);
                if (hold_prev) begin
                    check("hold_valid", tx_valid, 1);
                    check("hold_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_byte: got 0x%02h, expected no byte", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", tx_data, e);
                    end
                    pops++;
                end
                hold_prev = tx_valid && !tx_ready;
                prev_data = tx_data;
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input bit neg, input bit err, output int len);
        int t;
        t = 0;
        len = 0;
        res_data  = d;
        res_neg   = neg;
        res_err   = err;
        res_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!res_ready && t < 20000);
        if (!res_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: res_ready got 0, expected 1");
            res_valid = 1'b0;
            return;
        end
        @(posedge clk);
        len = model_frame(d, neg, err);
        #1 res_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (busy && cyc < 20000);
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: busy got 1, expected 0");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len;
        int          cyc;
        int          base;
        int          t;
        logic [31:0] d;
        bit          neg;
        bit          err;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_res_ready", res_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-rate frames: first byte one cycle after capture, then one per clock.
        tx_mode = 0;
        send(32'h00C0FFEE, 1'b0, 1'b0, len);
        wait_done(cyc);
        check("cycles_c0ffee", cyc, len + 1);
        send(32'h0000001A, 1'b1, 1'b0, len);
        wait_done(cyc);
        check("cycles_neg1a", cyc, len + 1);
        send(32'h00000000, 1'b0, 1'b0, len);
        wait_done(cyc);
        check("cycles_zero", cyc, len + 1);
        send(32'h12345678, 1'b1, 1'b1, len);
        wait_done(cyc);
        check("cycles_err", cyc, len + 1);

        // Slow transmitter with rare ready pulses.
        tx_mode = 2;
        send(32'hDEADBEEF, 1'b1, 1'b0, len);
        wait_done(cyc);

        // New word offered mid-frame must wait for the LF to be accepted.
        tx_mode = 1;
        send(32'hA5A50000, 1'b0, 1'b0, len);
        send(32'h00000F00, 1'b1, 1'b0, len);
        wait_done(cyc);

        // Reset while the third byte is presented.
        tx_mode = 0;
        base = pops;
        send(32'h89ABCDEF, 1'b0, 1'b0, len);
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (pops < base + 2 && t < 200);
        check("third_byte_reached", pops >= base + 2, 1);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx_data", tx_data, 0);
        rst = 1'b0;
        send(32'h0000ABCD, 1'b0, 1'b0, len);
        wait_done(cyc);
        check("cycles_after_rst", cyc, len + 1);

        for (int k = 0; k < 40; k++) begin
            tx_mode = $urandom_range(0, 1);
            d = $urandom;
            d = d >> (4 * $urandom_range(0, 8));
            neg = ($urandom_range(0, 2) == 0);
            err = ($urandom_range(0, 5) == 0);
            send(d, neg, err, len);
            if ($urandom_range(0, 1) == 1) wait_done(cyc);
        end
        wait_done(cyc);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
